instr_dispatch: RTL and testbench

Fetch/decode/dispatch sequencer directly upstream of the per-instruction FSMs (movi, mov, add, sub) in the simple CPU.
- Reads a 16-bit instruction word from synchronous instruction memory and splits it into opcode/Ri/num fields.
- Issues a one-cycle start pulse to the matching instruction FSM.
- Holds the operand fields stable and waits for that FSM's completion strobe (its start-next-instruction output) before fetching the next word.

---
 rtl/cpu_isa_pkg.sv | 27 ++
 rtl/instr_dispatch_op_decode.sv | 26 ++
 rtl/instr_dispatch.sv | 151 +++++++++++++++
 tb/tb_instr_dispatch.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the simple CPU: opcodes, instruction field
// positions and the dispatch sequencer state encoding.
package cpu_isa_pkg;

    localparam logic [3:0] OP_MOVI = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RI_MSB  = 11;
    localparam int RI_LSB  = 6;
    localparam int NUM_MSB = 5;
    localparam int NUM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_DISPATCH = 3'd3,
        ST_WAIT     = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

endpackage

// File: rtl/instr_dispatch_op_decode.sv
// Combinational opcode decoder: one-hot start vector (bit0 MOVI .. bit3 SUB)
// plus halt/illegal flags. Shared with the trace/debug block.
module op_decode
    import cpu_isa_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [3:0] o_start_vec,
    output logic       o_is_halt,
    output logic       o_is_illegal
);

    always_comb begin
        o_start_vec  = 4'b0000;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;
        case (i_opcode)
            OP_MOVI: o_start_vec  = 4'b0001;
            OP_MOV:  o_start_vec  = 4'b0010;
            OP_ADD:  o_start_vec  = 4'b0100;
            OP_SUB:  o_start_vec  = 4'b1000;
            OP_HALT: o_is_halt    = 1'b1;
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_dispatch.sv
// Fetch/decode/dispatch sequencer feeding the per-instruction FSMs.
// Optional WAIT watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module instr_dispatch
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [15:0]       instr_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              mem_rd,
    output logic [5:0]        Ri_out,
    output logic [5:0]        num_out,
    output logic              start_movi,
    output logic              start_mov,
    output logic              start_add,
    output logic              start_sub,
    input  logic              done_in,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        dbg_state
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_mem_rd;
    logic [3:0]          r_start;
    logic [5:0]          r_ri;
    logic [5:0]          r_num;
    logic                r_busy;
    logic                r_halted;
    logic                r_illegal;

    logic [3:0]          w_start_vec;
    logic                w_is_halt;
    logic                w_is_illegal;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]    r_wait_cnt;
`endif

    // instr_in is valid in DECODE (one cycle after the FETCH read strobe).
    op_decode u_op_decode (
        .i_opcode     (instr_in[OP_MSB:OP_LSB]),
        .o_start_vec  (w_start_vec),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    // Handshake: one start_* pulse per dispatched word; the FSM answers with a
    // single-cycle done_in, which is only honoured while in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_mem_rd  <= 1'b0;
            r_start   <= 4'b0000;
            r_ri      <= '0;
            r_num     <= '0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_mem_rd <= 1'b0;
            r_start  <= 4'b0000;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state  <= ST_FETCH;
                        r_mem_rd <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ri  <= instr_in[RI_MSB:RI_LSB];
                    r_num <= instr_in[NUM_MSB:NUM_LSB];
                    if (w_is_halt || w_is_illegal) begin
                        r_state   <= ST_HALT;
                        r_busy    <= 1'b0;
                        r_halted  <= 1'b1;
                        r_illegal <= w_is_illegal;
                    end else begin
                        r_state <= ST_DISPATCH;
                        r_start <= w_start_vec;
                    end
                end
                ST_DISPATCH: begin
                    r_state <= ST_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (done_in) begin
                        r_pc <= r_pc + ADDR_W'(1);
                        if (run) begin
                            r_state  <= ST_FETCH;
                            r_mem_rd <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
`ifdef DISPATCH_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_LAST) begin
                        r_state  <= ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out     = r_pc;
    assign mem_rd     = r_mem_rd;
    assign Ri_out     = r_ri;
    assign num_out    = r_num;
    assign start_movi = r_start[0];
    assign start_mov  = r_start[1];
    assign start_add  = r_start[2];
    assign start_sub  = r_start[3];
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign illegal    = r_illegal;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: directed scenarios plus random
// programs checked against a program-level interpreter model.
`timescale 1ns/1ps
module tb_instr_dispatch;
    import cpu_isa_pkg::*;

    localparam int ADDR_W = 8;
    localparam int TO_CYC = 64;
    localparam int EW     = ADDR_W + 14;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic              done_in = 1'b0;
    logic [15:0]       instr_in = 16'h0000;
    logic [ADDR_W-1:0] pc_out;
    logic              mem_rd;
    logic [5:0]        Ri_out;
    logic [5:0]        num_out;
    logic              start_movi, start_mov, start_add, start_sub;
    logic              busy, halted, illegal;
    logic [2:0]        dbg_state;

    logic [15:0]       mem [0:(1<<ADDR_W)-1];
    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     obs_q[$];
    int                n_checks = 0;
    int                n_fail = 0;

    instr_dispatch #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .reset(reset), .run(run), .instr_in(instr_in),
        .pc_out(pc_out), .mem_rd(mem_rd), .Ri_out(Ri_out), .num_out(num_out),
        .start_movi(start_movi), .start_mov(start_mov), .start_add(start_add),
        .start_sub(start_sub), .done_in(done_in), .busy(busy), .halted(halted),
        .illegal(illegal), .dbg_state(dbg_state)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) instr_in <= mem[pc_out];
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation exceeded 1ms, required completion");
        $fatal(1, "global timeout");
    end

    // ---------------- reference model ----------------
    // Interprets the program in mem from pc0: every legal word is one dispatch
    // event {pc, op, Ri, num}; HALT or an undefined opcode ends the run.
    function automatic void model_from(input logic [ADDR_W-1:0] pc0,
                                       output logic [ADDR_W-1:0] pc_end,
                                       output logic ill);
        logic [ADDR_W-1:0] pc;
        logic [15:0] w;
        pc = pc0;
        pc_end = pc0;
        ill = 1'b0;
        for (int n = 0; n < 600; n++) begin
            w = mem[pc];
            if (w[15:12] <= 4'd3) begin
                exp_q.push_back({pc, w[13:12], w[11:6], w[5:0]});
                pc = pc + 1'b1;
            end else begin
                pc_end = pc;
                ill = (w[15:12] != 4'hF);
                return;
            end
        end
        pc_end = pc;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b0; done_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_start(input int budget, output int k);
        k = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if ({start_movi, start_mov, start_add, start_sub} != 4'b0000) begin
                k = c;
                return;
            end
        end
    endtask

    // Acts as the downstream FSMs: answers each start with done_in after a
    // random delay, records every dispatch and checks start_* one-hotness.
    task automatic run_program(input int dmin, input int dmax, input int budget, input bit patch0);
        int cnt;
        bit finished;
        logic [3:0] st;
        logic [1:0] opi;
        cnt = -1;
        finished = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            done_in = (cnt == 0);
            if (cnt >= 0) cnt--;
            st = {start_movi, start_mov, start_add, start_sub};
            n_checks++;
            if ($countones(st) > 1) begin
                n_fail++;
                $display("FAIL start_onehot: starts=%b, required at most one high", st);
            end
            if (st != 4'b0000) begin
                opi = start_sub ? 2'd3 : start_add ? 2'd2 : start_mov ? 2'd1 : 2'd0;
                obs_q.push_back({pc_out, opi, Ri_out, num_out});
                cnt = $urandom_range(dmax, dmin) - 1;
                if (patch0) mem[0] = 16'hF000;
            end
            if (halted) begin
                finished = 1'b1;
                break;
            end
        end
        done_in = 1'b0;
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL program_timeout: halted=%b after %0d cycles, required 1", halted, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b1; done_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({pc_out, mem_rd, Ri_out, num_out, start_movi, start_mov, start_add, start_sub,
             busy, halted, illegal, dbg_state} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_values: got pc=%h rd=%b ri=%h num=%h st=%b busy=%b h=%b i=%b s=%0d, required all 0",
                     pc_out, mem_rd, Ri_out, num_out, {start_movi, start_mov, start_add, start_sub},
                     busy, halted, illegal, dbg_state);
        end
        reset = 1'b0; run = 1'b0;
    endtask

    task automatic test_movi_latency();
        int k;
        do_reset();
        mem[0] = 16'h000F;
        mem[1] = 16'hF000;
        run = 1'b1;
        wait_start(20, k);
        n_checks++;
        if (k !== 3) begin
            n_fail++;
            $display("FAIL movi_latency: start after %0d cycles, required 3", k);
        end
        n_checks++;
        if ({start_movi, start_mov, start_add, start_sub, Ri_out, num_out} !== {4'b1000, 6'd0, 6'd15}) begin
            n_fail++;
            $display("FAIL movi_fields: st=%b ri=%0d num=%0d, required st=1000 ri=0 num=15",
                     {start_movi, start_mov, start_add, start_sub}, Ri_out, num_out);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_WAIT || pc_out !== 8'd0 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL movi_wait: state=%0d pc=%0d rd=%b, required WAIT pc=0 rd=0", dbg_state, pc_out, mem_rd);
        end
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        n_checks++;
        if (pc_out !== 8'd1 || mem_rd !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL movi_done: pc=%0d rd=%b busy=%b, required pc=1 rd=1 busy=1", pc_out, mem_rd, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (halted !== 1'b1 || illegal !== 1'b0 || pc_out !== 8'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL movi_halt: h=%b i=%b pc=%0d busy=%b, required h=1 i=0 pc=1 busy=0",
                     halted, illegal, pc_out, busy);
        end
    endtask

    task automatic test_program();
        logic [ADDR_W-1:0] pc_end;
        logic ill;
        do_reset();
        mem[0] = 16'h104A; mem[1] = 16'h2085; mem[2] = 16'h30C3; mem[3] = 16'hF000;
        exp_q.delete(); obs_q.delete();
        model_from('0, pc_end, ill);
        run = 1'b1;
        run_program(2, 2, 200, 1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL program_count: %0d dispatches, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL program_event[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (halted !== 1'b1 || illegal !== ill || pc_out !== pc_end) begin
            n_fail++;
            $display("FAIL program_end: h=%b i=%b pc=%0d, required h=1 i=%b pc=%0d", halted, illegal, pc_out, ill, pc_end);
        end
    endtask

    task automatic test_illegal();
        int starts;
        do_reset();
        mem[0] = 16'h5000;
        run = 1'b1;
        starts = 0;
        repeat (8) begin
            @(negedge clk);
            if ({start_movi, start_mov, start_add, start_sub} != 4'b0000) starts++;
        end
        n_checks++;
        if (halted !== 1'b1 || illegal !== 1'b1 || starts != 0 || pc_out !== 8'd0 ||
            mem_rd !== 1'b0 || dbg_state !== ST_HALT) begin
            n_fail++;
            $display("FAIL illegal_halt: h=%b i=%b starts=%0d pc=%0d rd=%b s=%0d, required h=1 i=1 starts=0 pc=0 rd=0 HALT",
                     halted, illegal, starts, pc_out, mem_rd, dbg_state);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (halted !== 1'b0 || illegal !== 1'b0 || pc_out !== 8'd0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL illegal_clear: h=%b i=%b pc=%0d s=%0d, required 0 0 0 IDLE", halted, illegal, pc_out, dbg_state);
        end
        reset = 1'b0; run = 1'b0;
    endtask

    task automatic test_run_drop();
        int k;
        int rd_seen;
        do_reset();
        mem[0] = 16'h0123;
        mem[1] = 16'h1040;
        run = 1'b1;
        wait_start(20, k);
        run = 1'b0;
        repeat (2) @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        n_checks++;
        if (dbg_state !== ST_IDLE || pc_out !== 8'd1 || busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL rundrop_idle: s=%0d pc=%0d busy=%b rd=%b, required IDLE pc=1 busy=0 rd=0",
                     dbg_state, pc_out, busy, mem_rd);
        end
        rd_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_rd) rd_seen++;
        end
        n_checks++;
        if (rd_seen != 0) begin
            n_fail++;
            $display("FAIL rundrop_noread: %0d reads while idle, required 0", rd_seen);
        end
        run = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_rd !== 1'b1 || pc_out !== 8'd1) begin
            n_fail++;
            $display("FAIL rundrop_refetch: rd=%b pc=%0d, required rd=1 pc=1", mem_rd, pc_out);
        end
        wait_start(20, k);
        n_checks++;
        if ({start_movi, start_mov, start_add, start_sub, Ri_out, num_out} !== {4'b0100, 6'd1, 6'd0}) begin
            n_fail++;
            $display("FAIL rundrop_next: st=%b ri=%0d num=%0d, required st=0100 ri=1 num=0",
                     {start_movi, start_mov, start_add, start_sub}, Ri_out, num_out);
        end
    endtask

    task automatic test_done_in_dispatch();
        int k;
        do_reset();
        mem[0] = 16'h2000;
        run = 1'b1;
        wait_start(20, k);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_WAIT || pc_out !== 8'd0) begin
            n_fail++;
            $display("FAIL dispatch_done_ignored: s=%0d pc=%0d, required WAIT pc=0", dbg_state, pc_out);
        end
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        n_checks++;
        if (pc_out !== 8'd1 || mem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL dispatch_done_late: pc=%0d rd=%b, required pc=1 rd=1", pc_out, mem_rd);
        end
    endtask

    task automatic test_reset_in_wait();
        int k;
        do_reset();
        mem[0] = 16'h3041;
        run = 1'b1;
        wait_start(20, k);
        repeat (2) @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_WAIT) begin
            n_fail++;
            $display("FAIL rstwait_pre: s=%0d, required WAIT", dbg_state);
        end
        reset = 1'b1; run = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pc_out, mem_rd, Ri_out, num_out, start_movi, start_mov, start_add, start_sub,
             busy, halted, illegal, dbg_state} !== 31'd0) begin
            n_fail++;
            $display("FAIL rstwait_values: pc=%h rd=%b ri=%h num=%h busy=%b s=%0d, required all 0",
                     pc_out, mem_rd, Ri_out, num_out, busy, dbg_state);
        end
        reset = 1'b0;
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc_out !== 8'd0 || dbg_state !== ST_IDLE || busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_stale_done: pc=%0d s=%0d busy=%b rd=%b, required pc=0 IDLE 0 0",
                     pc_out, dbg_state, busy, mem_rd);
        end
        run = 1'b1;
        wait_start(20, k);
        n_checks++;
        if (k !== 3 || start_sub !== 1'b1 || Ri_out !== 6'd1 || num_out !== 6'd1) begin
            n_fail++;
            $display("FAIL rstwait_redispatch: k=%0d sub=%b ri=%0d num=%0d, required 3 1 1 1",
                     k, start_sub, Ri_out, num_out);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] pc_end;
        logic ill;
        logic [3:0] op;
        logic [11:0] fld;
        int len;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            len = $urandom_range(12, 1);
            for (int i = 0; i < len; i++) begin
                op = 4'($urandom_range(3, 0));
                fld = 12'($urandom());
                mem[i] = {op, fld};
            end
            op = ($urandom_range(1, 0) == 1) ? 4'hF : 4'($urandom_range(14, 4));
            fld = 12'($urandom());
            mem[len] = {op, fld};
            exp_q.delete(); obs_q.delete();
            model_from('0, pc_end, ill);
            run = 1'b1;
            run_program(1, 5, 400, 1'b0);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL random_count[%0d]: %0d dispatches, required %0d", it, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random_event[%0d][%0d]: got %h, required %h", it, i, obs_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (halted !== 1'b1 || illegal !== ill || pc_out !== pc_end) begin
                n_fail++;
                $display("FAIL random_end[%0d]: h=%b i=%b pc=%0d, required h=1 i=%b pc=%0d",
                         it, halted, illegal, pc_out, ill, pc_end);
            end
        end
    endtask

    task automatic test_pc_wrap();
        logic [ADDR_W-1:0] pc_end;
        logic ill;
        logic [15:0] w0;
        do_reset();
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = {4'($urandom_range(3, 0)), 12'($urandom())};
        end
        w0 = mem[0];
        exp_q.delete(); obs_q.delete();
        mem[0] = 16'hF000;
        model_from(8'd1, pc_end, ill);
        exp_q.push_front({8'd0, w0[13:12], w0[11:6], w0[5:0]});
        mem[0] = w0;
        run = 1'b1;
        run_program(1, 1, 2000, 1'b1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_count: %0d dispatches, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_event[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (halted !== 1'b1 || illegal !== 1'b0 || pc_out !== pc_end) begin
            n_fail++;
            $display("FAIL wrap_end: h=%b i=%b pc=%0d, required h=1 i=0 pc=%0d", halted, illegal, pc_out, pc_end);
        end
    endtask

`ifdef DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        int w;
        do_reset();
        mem[0] = 16'h0001;
        run = 1'b1;
        wait_start(20, k);
        w = 0;
        for (int c = 0; c < 4 * TO_CYC; c++) begin
            @(negedge clk);
            if (dbg_state == ST_WAIT) w++;
            if (halted) break;
        end
        n_checks++;
        if (w != TO_CYC || halted !== 1'b1 || illegal !== 1'b0 || pc_out !== 8'd0) begin
            n_fail++;
            $display("FAIL timeout_halt: wait=%0d h=%b i=%b pc=%0d, required wait=%0d h=1 i=0 pc=0",
                     w, halted, illegal, pc_out, TO_CYC);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'hF000;
        test_reset();
        test_movi_latency();
        test_program();
        test_illegal();
        test_run_drop();
        test_done_in_dispatch();
        test_reset_in_wait();
        test_random();
        test_pc_wrap();
`ifdef DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
